// File: rtl/inst_loader.sv
// Boot-time instruction loader: buffers host words in a small FIFO and streams them
// into synchronous main memory, then releases the CPU sequencer once the program is in.
module inst_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  input  logic              load_last,
  output logic              instr_ready,
  input  logic              mem_stall,
  output logic              memwe,
  output logic [ADDR_W-1:0] memaddr,
  output logic [15:0]       memdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              cpu_run,
  output logic              err
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    RUN,
    ERR
  } state_t;

  state_t            state;
  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic [ADDR_W-1:0] addr_cnt;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop_due;
  logic overflow;
  logic pop;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    fifo_full   = 1'b0;
    fifo_empty  = 1'b0;
    instr_ready = 1'b0;
    push        = 1'b0;
    pop_due     = 1'b0;
    overflow    = 1'b0;
    pop         = 1'b0;

    fifo_full  = (fifo_cnt == FULL_CNT);
    fifo_empty = (fifo_cnt == '0);

    // Readiness looks only at the registered occupancy: a full FIFO refuses a word
    // even when a pop frees a slot in the same cycle.
    instr_ready = (state == LOAD) && !fifo_full;
    push        = instr_valid && instr_ready;

    pop_due  = ((state == LOAD) || (state == DRAIN)) && !fifo_empty && !mem_stall;
    overflow = pop_due && (words_loaded == MAX_WORDS);
    pop      = pop_due && !overflow;
  end

  // NOTE: the buffer storage has no reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= instr;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= LOAD;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      addr_cnt     <= '0;
      words_loaded <= '0;
      memwe        <= 1'b0;
      memaddr      <= '0;
      memdata      <= '0;
      cpu_run      <= 1'b0;
      err          <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every read sees the pre-edge value.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      memwe <= pop;
      if (pop) begin
        memaddr      <= addr_cnt;
        memdata      <= fifo_mem[rd_ptr];
        words_loaded <= words_loaded + (ADDR_W + 1)'(1);
        // Saturate rather than wrap; the overflow check stops any write past the top.
        if (addr_cnt != '1) begin
          addr_cnt <= addr_cnt + ADDR_W'(1);
        end
      end

      unique case (state)
        LOAD: begin
          if (overflow) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (push && load_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (overflow) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (fifo_empty) begin
            state   <= RUN;
            cpu_run <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        ERR: begin
          state <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a wide instance (ADDR_W=8) and a narrow one (ADDR_W=2)
// share stimulus; a per-instance scoreboard checks every memory write.
module tb_inst_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        load_last = 1'b0;
  logic        mem_stall = 1'b0;

  logic        instr_ready, memwe, cpu_run, err;
  logic [7:0]  memaddr;
  logic [15:0] memdata;
  logic [8:0]  words_loaded;

  logic        s_instr_ready, s_memwe, s_cpu_run, s_err;
  logic [1:0]  s_memaddr;
  logic [15:0] s_memdata;
  logic [2:0]  s_words_loaded;

  inst_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clock(clock), .resetn(resetn), .instr(instr), .instr_valid(instr_valid),
    .load_last(load_last), .instr_ready(instr_ready), .mem_stall(mem_stall),
    .memwe(memwe), .memaddr(memaddr), .memdata(memdata),
    .words_loaded(words_loaded), .cpu_run(cpu_run), .err(err)
  );

  inst_loader #(.ADDR_W(2), .FIFO_DEPTH(4)) dut_small (
    .clock(clock), .resetn(resetn), .instr(instr), .instr_valid(instr_valid),
    .load_last(load_last), .instr_ready(s_instr_ready), .mem_stall(mem_stall),
    .memwe(s_memwe), .memaddr(s_memaddr), .memdata(s_memdata),
    .words_loaded(s_words_loaded), .cpu_run(s_cpu_run), .err(s_err)
  );

  typedef struct {
    int          addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t s_exp_q[$];
  int   exp_addr, s_exp_addr;
  int   wr_count, s_wr_count, acc_count;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic l);
    instr_valid = v;
    instr       = d;
    load_last   = l;
  endtask

  // One clock cycle: retire writes from the previous edge, record accepted words, then clock.
  task automatic step();
    exp_t e;
    @(negedge clock);
    if (memwe) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(memwe), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_addr", 32'(memaddr), 32'(e.addr));
        check("sb_data", 32'(memdata), 32'(e.data));
      end
    end
    if (s_memwe) begin
      s_wr_count++;
      if (s_exp_q.size() == 0) begin
        check("s_unexpected_write", 32'(s_memwe), 32'd0);
      end else begin
        e = s_exp_q.pop_front();
        check("s_sb_addr", 32'(s_memaddr), 32'(e.addr));
        check("s_sb_data", 32'(s_memdata), 32'(e.data));
      end
    end
    if (instr_valid && instr_ready) begin
      exp_q.push_back('{exp_addr, instr});
      exp_addr++;
      acc_count++;
    end
    if (instr_valid && s_instr_ready) begin
      s_exp_q.push_back('{s_exp_addr, instr});
      s_exp_addr++;
    end
    @(posedge clock);
    #1;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases after one edge.
  task automatic do_reset();
    drive(1'b0, 16'h0000, 1'b0);
    mem_stall = 1'b0;
    resetn    = 1'b0;
    #1;
    check("rst_memwe", 32'(memwe), 32'd0);
    check("rst_memaddr", 32'(memaddr), 32'd0);
    check("rst_memdata", 32'(memdata), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_s_err", 32'(s_err), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    exp_q.delete();
    s_exp_q.delete();
    exp_addr   = 0;
    s_exp_addr = 0;
    wr_count   = 0;
    s_wr_count = 0;
    acc_count  = 0;
    check("rst_ready_after_release", 32'(instr_ready), 32'd1);
  endtask

  initial begin
    // Three back-to-back words, load_last on the third
    do_reset();
    drive(1'b1, 16'h1111, 1'b0); step();
    check("s1_accept_latency", 32'(memwe), 32'd0);
    drive(1'b1, 16'h2222, 1'b0); step();
    check("s1_we_c2", 32'(memwe), 32'd1);
    drive(1'b1, 16'h3333, 1'b1); step();
    check("s1_we_c3", 32'(memwe), 32'd1);
    drive(1'b0, 16'h0000, 1'b0); step();
    check("s1_we_c4", 32'(memwe), 32'd1);
    check("s1_run_not_yet", 32'(cpu_run), 32'd0);
    step();
    check("s1_we_off", 32'(memwe), 32'd0);
    check("s1_cpu_run", 32'(cpu_run), 32'd1);
    check("s1_words", 32'(words_loaded), 32'd3);
    check("s1_ready_run", 32'(instr_ready), 32'd0);
    step();
    check("s1_wr_count", 32'(wr_count), 32'd3);
    check("s1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Single word; RUN then ignores instr_valid and mem_stall
    do_reset();
    drive(1'b1, 16'hABCD, 1'b1); step();
    drive(1'b0, 16'h0000, 1'b0); step();
    check("s2_we", 32'(memwe), 32'd1);
    step();
    check("s2_cpu_run", 32'(cpu_run), 32'd1);
    check("s2_ready", 32'(instr_ready), 32'd0);
    drive(1'b1, 16'h7777, 1'b1);
    mem_stall = 1'b1;
    step(); step();
    check("s2_ready_hold", 32'(instr_ready), 32'd0);
    check("s2_run_hold", 32'(cpu_run), 32'd1);
    check("s2_wr_count", 32'(wr_count), 32'd1);
    check("s2_words", 32'(words_loaded), 32'd1);

    // Stalled memory: pushes continue until full, then drain in order on release
    do_reset();
    mem_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'(32'h5000 + i), 1'b0);
      step();
    end
    check("s3_accepted", 32'(acc_count), 32'd4);
    check("s3_ready_full", 32'(instr_ready), 32'd0);
    check("s3_no_write_stalled", 32'(wr_count), 32'd0);
    drive(1'b0, 16'h0000, 1'b0);
    mem_stall = 1'b0;
    repeat (6) step();
    check("s3_wr_count", 32'(wr_count), 32'd4);
    check("s3_words", 32'(words_loaded), 32'd4);
    check("s3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Overflow on the narrow instance: fifth pop must not write
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(32'h6000 + i), (i == 4));
      step();
    end
    check("s4_err_before", 32'(s_err), 32'd0);
    drive(1'b0, 16'h0000, 1'b0); step();
    check("s4_err", 32'(s_err), 32'd1);
    check("s4_we_blocked", 32'(s_memwe), 32'd0);
    check("s4_no_run", 32'(s_cpu_run), 32'd0);
    check("s4_ready", 32'(s_instr_ready), 32'd0);
    check("s4_addr_hold", 32'(s_memaddr), 32'd3);
    check("s4_words", 32'(s_words_loaded), 32'd4);
    step(); step();
    check("s4_err_sticky", 32'(s_err), 32'd1);
    check("s4_run_still_0", 32'(s_cpu_run), 32'd0);
    check("s4_wr_count", 32'(s_wr_count), 32'd4);
    check("s4_unwritten", 32'(s_exp_q.size()), 32'd1);
    check("s4_wide_run", 32'(cpu_run), 32'd1);
    check("s4_wide_words", 32'(words_loaded), 32'd5);
    check("s4_wide_wr_count", 32'(wr_count), 32'd5);

    // Reset mid-load, then a fresh two-word load starts at address 0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(32'h8000 + i), 1'b0);
      step();
    end
    check("s5_mid_we", 32'(memwe), 32'd1);
    check("s5_mid_addr", 32'(memaddr), 32'd1);
    do_reset();
    drive(1'b1, 16'h9001, 1'b0); step();
    drive(1'b1, 16'h9002, 1'b1); step();
    drive(1'b0, 16'h0000, 1'b0);
    repeat (4) step();
    check("s5_words", 32'(words_loaded), 32'd2);
    check("s5_wr_count", 32'(wr_count), 32'd2);
    check("s5_cpu_run", 32'(cpu_run), 32'd1);
    check("s5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Simultaneous push and pop with two words held leaves occupancy at two
    do_reset();
    mem_stall = 1'b1;
    drive(1'b1, 16'hC001, 1'b0); step();
    drive(1'b1, 16'hC002, 1'b0); step();
    mem_stall = 1'b0;
    drive(1'b1, 16'hC003, 1'b0); step();
    check("s6_pop_we", 32'(memwe), 32'd1);
    check("s6_pop_addr", 32'(memaddr), 32'd0);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(32'hC004 + i), 1'b0);
      step();
    end
    check("s6_accepted", 32'(acc_count), 32'd5);
    check("s6_ready_full", 32'(instr_ready), 32'd0);
    drive(1'b0, 16'h0000, 1'b0);
    mem_stall = 1'b0;
    repeat (7) step();
    check("s6_wr_count", 32'(wr_count), 32'd5);
    check("s6_words", 32'(words_loaded), 32'd5);
    check("s6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
